// File: rtl/character_controller.sv
// Per-player fighting-game character: walking, three-phase attack and hitstun,
// advanced once per video frame with a clamped horizontal position.
module character_controller #(
    parameter int START_X         = 100,
    parameter int GROUND_Y        = 200,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 544,
    parameter int SPEED_FWD       = 3,
    parameter int SPEED_BACK      = 2,
    parameter int STARTUP_FRAMES  = 5,
    parameter int ACTIVE_FRAMES   = 2,
    parameter int RECOVERY_FRAMES = 16,
    parameter int HITSTUN_FRAMES  = 15,
    parameter int KNOCKBACK       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       hit_in,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] state,
    output logic       attacking
);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_MOVE_L       = 3'd1,
        ST_MOVE_R       = 3'd2,
        ST_HITSTUN      = 3'd3,
        ST_ATK_STARTUP  = 3'd4,
        ST_ATK_ACTIVE   = 3'd5,
        ST_ATK_RECOVERY = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  x_q, x_d;
    logic        attacking_q, attacking_d;
    logic        hit_pend_q, hit_pend_d;
    logic        atk_prev_q, atk_prev_d;

    logic        hit_eff_s;
    logic        atk_req_s;
    logic        free_s;
    logic signed [10:0] move_s;
    logic signed [10:0] x_sum_s;
    logic [9:0]  x_next_s;

    // State register and all output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            x_q         <= 10'(START_X);
            attacking_q <= 1'b0;
            hit_pend_q  <= 1'b0;
            atk_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            attacking_q <= attacking_d;
            hit_pend_q  <= hit_pend_d;
            atk_prev_q  <= atk_prev_d;
        end
    end

    // Frame decision: hit, timed-state countdown, then free-state input handling
    always_comb begin
        hit_eff_s   = hit_pend_q | hit_in;
        atk_req_s   = btn_attack & ~atk_prev_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        attacking_d = attacking_q;
        atk_prev_d  = atk_prev_q;
        hit_pend_d  = hit_pend_q | hit_in;
        free_s      = 1'b0;
        if (frame_tick) begin
            // A hit arriving with the tick is consumed by that same tick.
            hit_pend_d = 1'b0;
            atk_prev_d = btn_attack;
            if (hit_eff_s) begin
                state_d = ST_HITSTUN;
                cnt_d   = 4'(HITSTUN_FRAMES - 1);
            end else if (state_q inside {ST_HITSTUN, ST_ATK_STARTUP,
                                         ST_ATK_ACTIVE, ST_ATK_RECOVERY}) begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    case (state_q)
                        ST_ATK_STARTUP: begin
                            state_d = ST_ATK_ACTIVE;
                            cnt_d   = 4'(ACTIVE_FRAMES - 1);
                        end
                        ST_ATK_ACTIVE: begin
                            state_d = ST_ATK_RECOVERY;
                            cnt_d   = 4'(RECOVERY_FRAMES - 1);
                        end
                        default: free_s = 1'b1;
                    endcase
                end
            end else begin
                free_s = 1'b1;
            end
            if (free_s) begin
                if (atk_req_s) begin
                    state_d = ST_ATK_STARTUP;
                    cnt_d   = 4'(STARTUP_FRAMES - 1);
                end else if (btn_left ^ btn_right) begin
                    state_d = btn_left ? ST_MOVE_L : ST_MOVE_R;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                free_s = 1'b0;
            end
            x_d         = x_next_s;
            attacking_d = (state_d == ST_ATK_ACTIVE);
        end else begin
            hit_pend_d = hit_pend_q | hit_in;
        end
    end

    // Movement for the newly chosen state, widened to 11-bit signed before clamping
    always_comb begin
        case (state_d)
            ST_MOVE_R:  move_s = 11'(SPEED_FWD);
            ST_MOVE_L:  move_s = -11'(SPEED_BACK);
            ST_HITSTUN: move_s = -11'(KNOCKBACK);
            default:    move_s = 11'sd0;
        endcase
        x_sum_s = $signed({1'b0, x_q}) + move_s;
        if (x_sum_s < $signed(11'(X_MIN))) begin
            x_next_s = 10'(X_MIN);
        end else if (x_sum_s > $signed(11'(X_MAX))) begin
            x_next_s = 10'(X_MAX);
        end else begin
            x_next_s = x_sum_s[9:0];
        end
    end

    assign x_pos     = x_q;
    assign y_pos     = 10'(GROUND_Y);
    assign state     = state_q;
    assign attacking = attacking_q;

endmodule

// File: doc/character_controller.md
Name: character_controller

Overview:
- Per-player character state machine; produces x_pos, y_pos, attacking and state, which the sprite/hitbox renderer consumes.
- Advances once per video frame on frame_tick.
- Handles walking, the three attack phases (startup, active, recovery) and hitstun, with position clamping.
- One instance per player; the top level ANDs button inputs with game-enable.

Parameters:
- START_X, 100: x_pos after reset.
- GROUND_Y, 200: constant y_pos.
- X_MIN, 0: leftmost legal x_pos.
- X_MAX, 544: rightmost legal x_pos (640 − 64 body − 32 hitbox).
- SPEED_FWD, 3: pixels per frame moving right.
- SPEED_BACK, 2: pixels per frame moving left.
- STARTUP_FRAMES, 5: frames in ATK_STARTUP.
- ACTIVE_FRAMES, 2: frames in ATK_ACTIVE.
- RECOVERY_FRAMES, 16: frames in ATK_RECOVERY.
- HITSTUN_FRAMES, 15: frames in HITSTUN.
- KNOCKBACK, 4: pixels per frame pushed left during HITSTUN.

Ports:
- clk  in  1  system clock (pixel clock domain)
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- btn_left  in  1  debounced, level
- btn_right  in  1  debounced, level
- btn_attack  in  1  debounced, level
- hit_in  in  1  one-cycle pulse from collision logic: this character was hit
- x_pos  out  10  sprite top-left X
- y_pos  out  10  sprite top-left Y, always GROUND_Y
- state  out  3  0 IDLE, 1 MOVE_L, 2 MOVE_R, 3 HITSTUN, 4 ATK_STARTUP, 5 ATK_ACTIVE, 6 ATK_RECOVERY
- attacking  out  1  high iff state == ATK_ACTIVE

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset values: x_pos = START_X, y_pos = GROUND_Y, state = IDLE, attacking = 0, frame counter = 0, hit latch = 0, attack-edge history = 0.
  - Reset has priority over everything, including a coincident frame_tick or hit_in.
- Registering and timing:
  - All outputs are registered and change only in the cycle after a frame_tick (1-cycle latency).
  - Exception: reset.
- Hit latch:
  - hit_in sets hit_pend on any cycle.
  - The latch clears on the frame_tick that consumes it.
  - hit_in coincident with frame_tick is consumed by that same tick.
- Attack request:
  - atk_req = btn_attack & ~atk_prev, evaluated only at frame_tick.
  - atk_prev updates only at frame_tick.
  - Holding the button yields one attack.
- Decision at each frame_tick, in priority order:
  1. hit_pend → HITSTUN, counter = HITSTUN_FRAMES−1. This applies from any state, including HITSTUN itself (counter reloads).
  2. State is ATK_* or HITSTUN with counter ≠ 0 → counter decrements; stay in state.
  3. State is ATK_* or HITSTUN with counter = 0, per state:
     - ATK_STARTUP → ATK_ACTIVE, counter = ACTIVE_FRAMES−1.
     - ATK_ACTIVE → ATK_RECOVERY, counter = RECOVERY_FRAMES−1.
     - ATK_RECOVERY and HITSTUN → re-evaluate as a free state (step 4) in the same tick.
  4. Free states (IDLE, MOVE_L, MOVE_R):
     - atk_req → ATK_STARTUP, counter = STARTUP_FRAMES−1.
     - else btn_left xor btn_right → MOVE_L or MOVE_R.
     - else IDLE.
     - Both directions held → IDLE.
- Movement, applied on the same tick as the state decision and using the new state:
  - MOVE_R: x += SPEED_FWD.
  - MOVE_L: x −= SPEED_BACK.
  - HITSTUN: x −= KNOCKBACK.
  - Any other state: no movement.
- Arithmetic and clamping:
  - Computed in 11-bit signed form, then clamped to [X_MIN, X_MAX].
  - No 10-bit wrap-around is ever visible on x_pos.
- Frame cadence: movement in MOVE_L/MOVE_R continues every frame while the button is held.
- Attack frames: total frames from attack to free = STARTUP_FRAMES + ACTIVE_FRAMES + RECOVERY_FRAMES (23 with defaults). No movement is permitted during them.
- Between ticks: no state, position or output change except the hit latch and reset.

Test Plan:
- Reset then 10 ticks with no buttons → x_pos = 100, state = 0, attacking = 0 throughout; y_pos = 200.
- Hold btn_right for 4 ticks → state 2, x_pos 103, 106, 109, 112; release → state 0 at the next tick, x_pos = 112.
- Attack pulse held across 30 ticks:
  - state 4 for 5 ticks, then state 5 with attacking = 1 for exactly 2 ticks, then state 6 for 16 ticks, then state 0.
  - No second attack while the button stays held.
- Clamping at both edges:
  - Start x_pos = 2, hold btn_left → 0, 0.
  - Drive to 543 with btn_right → 544 and stays 544, never wraps.
- hit_in pulse mid-cycle during ATK_ACTIVE:
  - Next tick → state 3, attacking = 0.
  - 15 ticks of HITSTUN with x −4 per tick (100 → 40).
  - Then state 0.
  - A second hit_in during HITSTUN reloads the counter to 15 frames.
- Reset asserted during ATK_RECOVERY coincident with frame_tick and hit_in → next cycle x_pos = 100, state = 0, hit latch clear; the following tick stays IDLE.
